// File: rtl/reg_sel_decoder_pkg.sv
// reg_sel_decoder_pkg: shared state encoding and one-hot helper for register-select logic
package reg_sel_decoder_pkg;
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  // Only the low sel_w bits of idx are used; the result is sized for the widest supported select.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx, input int unsigned sel_w);
    logic [MAX_SEL_W-1:0] w_mask;
    w_mask = MAX_SEL_W'((32'd1 << sel_w) - 32'd1);
    return MAX_OUT_W'(1) << (idx & w_mask);
  endfunction
endpackage

// File: rtl/reg_sel_decoder_onehot_dec.sv
// onehot_dec: combinational SEL_W-to-2**SEL_W one-hot decoder
module onehot_dec
  import reg_sel_decoder_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      i_sel,
  output logic [(1<<SEL_W)-1:0] o_onehot
);
  localparam int OUT_W = 1 << SEL_W;
  assign o_onehot = OUT_W'(onehot(MAX_SEL_W'(i_sel), SEL_W));
endmodule

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: registered one-hot register-select decoder with full-range sweep mode
module reg_sel_decoder
  import reg_sel_decoder_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter bit HOLD_LAST = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [SEL_W-1:0]      dec_input,
  input  logic                  dec_en,
  input  logic                  sweep_start,
  output logic [(1<<SEL_W)-1:0] dec_output,
  output logic                  dec_valid,
  output logic                  sweep_busy,
  output logic                  sweep_done
);
  localparam int OUT_W = 1 << SEL_W;
  state_t           r_state;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_sel;
  logic [OUT_W-1:0] w_onehot;
  // The counter stays at zero in IDLE, but a starting sweep forces index 0 explicitly.
  assign w_sel = (r_state == SWEEP) ? r_cnt : (sweep_start ? '0 : dec_input);
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_sel   (w_sel),
    .o_onehot(w_onehot)
  );
  // Mode FSM: sweep start beats decode in IDLE; all requests are ignored while sweeping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      dec_output <= '0;
      dec_valid  <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else if (r_state == SWEEP) begin
      dec_output <= w_onehot;
      dec_valid  <= 1'b1;
      sweep_busy <= 1'b1;
      r_cnt      <= r_cnt + SEL_W'(1);
      sweep_done <= (r_cnt == '1);
      if (r_cnt == '1) r_state <= IDLE;
    end else begin
      sweep_done <= 1'b0;
      sweep_busy <= sweep_start;
      dec_valid  <= sweep_start | dec_en;
      if (sweep_start) begin
        r_state    <= SWEEP;
        r_cnt      <= SEL_W'(1);
        dec_output <= w_onehot;
      end else if (dec_en) begin
        dec_output <= w_onehot;
      end else if (!HOLD_LAST) begin
        dec_output <= '0;
      end
    end
  end
endmodule

// File: tb/tb_reg_sel_decoder.sv
// tb_reg_sel_decoder: directed checks of decode, sweep, collision and reset behaviour
module tb_reg_sel_decoder;
  logic        clk, clr_n, dec_en, sweep_start, mon_en;
  logic [4:0]  din;
  logic [15:0] o4, o4h;
  logic [3:0]  o2;
  logic [31:0] o5;
  logic        v4, b4, d4, v4h, b4h, d4h, v2, b2, d2, v5, b5, d5;
  int          n_chk, n_err;
  typedef struct {
    logic        en;
    logic [4:0]  din;
    logic [15:0] e0;
    logic [15:0] eh;
    logic        v;
  } vec_t;
  vec_t tbl[8];
  reg_sel_decoder #(.SEL_W(4), .HOLD_LAST(1'b0)) u4 (.clk(clk), .clr_n(clr_n), .dec_input(din[3:0]), .dec_en(dec_en),
    .sweep_start(sweep_start), .dec_output(o4), .dec_valid(v4), .sweep_busy(b4), .sweep_done(d4));
  reg_sel_decoder #(.SEL_W(4), .HOLD_LAST(1'b1)) u4h (.clk(clk), .clr_n(clr_n), .dec_input(din[3:0]), .dec_en(dec_en),
    .sweep_start(sweep_start), .dec_output(o4h), .dec_valid(v4h), .sweep_busy(b4h), .sweep_done(d4h));
  reg_sel_decoder #(.SEL_W(2), .HOLD_LAST(1'b0)) u2 (.clk(clk), .clr_n(clr_n), .dec_input(din[1:0]), .dec_en(dec_en),
    .sweep_start(sweep_start), .dec_output(o2), .dec_valid(v2), .sweep_busy(b2), .sweep_done(d2));
  reg_sel_decoder #(.SEL_W(5), .HOLD_LAST(1'b0)) u5 (.clk(clk), .clr_n(clr_n), .dec_input(din), .dec_en(dec_en),
    .sweep_start(sweep_start), .dec_output(o5), .dec_valid(v5), .sweep_busy(b5), .sweep_done(d5));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Never more than one output bit high; exactly one whenever valid.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("atmost1_u4", 32'($onehot0(o4)), 1);
      chk("atmost1_u4h", 32'($onehot0(o4h)), 1);
      chk("atmost1_u2", 32'($onehot0(o2)), 1);
      chk("atmost1_u5", 32'($onehot0(o5)), 1);
      if (v4) chk("onehot_u4", 32'($onehot(o4)), 1);
      if (v2) chk("onehot_u2", 32'($onehot(o2)), 1);
      if (v5) chk("onehot_u5", 32'($onehot(o5)), 1);
    end
  end
  initial begin
    n_chk = 0; n_err = 0; mon_en = 1'b0;
    clr_n = 1'b0; dec_en = 1'b0; sweep_start = 1'b0; din = '0;
    tbl[0] = '{1'b1, 5'h1A, 16'h0400, 16'h0400, 1'b1};
    tbl[1] = '{1'b0, 5'h1A, 16'h0000, 16'h0400, 1'b0};
    tbl[2] = '{1'b1, 5'h00, 16'h0001, 16'h0001, 1'b1};
    tbl[3] = '{1'b1, 5'h0F, 16'h8000, 16'h8000, 1'b1};
    tbl[4] = '{1'b0, 5'h03, 16'h0000, 16'h8000, 1'b0};
    tbl[5] = '{1'b1, 5'h15, 16'h0020, 16'h0020, 1'b1};
    tbl[6] = '{1'b1, 5'h1C, 16'h1000, 16'h1000, 1'b1};
    tbl[7] = '{1'b0, 5'h1C, 16'h0000, 16'h1000, 1'b0};
    tick(); tick();
    chk("rst_out", 32'(o4), 0);
    chk("rst_flags", {29'd0, v4, b4, d4}, 0);
    mon_en = 1'b1;
    clr_n = 1'b1;
    tick();
    chk("rel_idle", {29'd0, v4, b4, d4}, 0);
    // Decode vectors
    for (int i = 0; i < 8; i++) begin
      dec_en = tbl[i].en; din = tbl[i].din;
      tick();
      chk($sformatf("dec%0d_out", i), 32'(o4), 32'(tbl[i].e0));
      chk($sformatf("dec%0d_vld", i), 32'(v4), 32'(tbl[i].v));
      chk($sformatf("dec%0d_hold_out", i), 32'(o4h), 32'(tbl[i].eh));
      chk($sformatf("dec%0d_hold_vld", i), 32'(v4h), 32'(tbl[i].v));
      chk($sformatf("dec%0d_w2", i), 32'(o2), tbl[i].en ? 32'd1 << tbl[i].din[1:0] : 32'd0);
      chk($sformatf("dec%0d_w5", i), o5, tbl[i].en ? 32'd1 << tbl[i].din : 32'd0);
    end
    // Asynchronous reset between clock edges
    dec_en = 1'b1; din = 5'h07;
    tick();
    chk("pre_async_out", 32'(o4), 32'h0080);
    #2 clr_n = 1'b0;
    #1;
    chk("async_out", 32'(o4), 0);
    chk("async_hold_out", 32'(o4h), 0);
    chk("async_flags", {29'd0, v4, b4, d4}, 0);
    dec_en = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    chk("post_async_idle", {29'd0, v4, b4, d4}, 0);
    // Full sweeps on all widths at once
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (k < 16) begin
        chk($sformatf("sw4_out%0d", k), 32'(o4), 32'd1 << k);
        chk($sformatf("sw4_flags%0d", k), {29'd0, v4, b4, d4}, {29'd0, 1'b1, 1'b1, k == 15});
      end else begin
        chk($sformatf("sw4_idle_out%0d", k), 32'(o4), 0);
        chk($sformatf("sw4_idle_flags%0d", k), {29'd0, v4, b4, d4}, 0);
        chk($sformatf("sw4h_hold%0d", k), {15'd0, v4h, o4h}, 32'h8000);
      end
      if (k < 4) begin
        chk($sformatf("sw2_out%0d", k), 32'(o2), 32'd1 << k);
        chk($sformatf("sw2_flags%0d", k), {29'd0, v2, b2, d2}, {29'd0, 1'b1, 1'b1, k == 3});
      end else begin
        chk($sformatf("sw2_idle%0d", k), {25'd0, o2, v2, b2, d2}, 0);
      end
      if (k < 32) begin
        chk($sformatf("sw5_out%0d", k), o5, 32'd1 << k);
        chk($sformatf("sw5_flags%0d", k), {29'd0, v5, b5, d5}, {29'd0, 1'b1, 1'b1, k == 31});
      end else begin
        chk("sw5_idle_out", o5, 0);
        chk("sw5_idle_flags", {29'd0, v5, b5, d5}, 0);
      end
      tick();
    end
    // Counters wrapped back to zero: a new sweep restarts at bit 0
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("wrap_u2_first", 32'(o2), 1);
    chk("wrap_u5_first", o5, 1);
    chk("wrap_u4_first", 32'(o4), 1);
    tick();
    chk("wrap_u2_second", 32'(o2), 2);
    chk("wrap_u5_second", o5, 2);
    for (int k = 0; k < 32; k++) tick();
    chk("all_idle", {28'd0, b4, b4h, b2, b5}, 0);
    // Collision: sweep wins over decode; requests mid-sweep ignored
    din = 5'h05; dec_en = 1'b1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("coll_first", 32'(o4), 32'h0001);
    chk("coll_flags", {29'd0, v4, b4, d4}, 32'b110);
    for (int k = 1; k < 16; k++) begin
      sweep_start = (k == 8);
      tick();
      chk($sformatf("coll_out%0d", k), 32'(o4), 32'd1 << k);
      chk($sformatf("coll_done%0d", k), 32'(d4), 32'(k == 15));
    end
    // Back-to-back restart right after the terminal step
    sweep_start = 1'b1; dec_en = 1'b0;
    tick();
    sweep_start = 1'b0;
    chk("b2b_out", 32'(o4), 32'h0001);
    chk("b2b_flags", {29'd0, v4, b4, d4}, 32'b110);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("b2b_out%0d", k), 32'(o4), 32'd1 << k);
    end
    // Reset in the middle of the sweep
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_out", 32'(o4), 0);
    chk("midrst_flags", {29'd0, v4, b4, d4}, 0);
    tick();
    chk("midrst_hold", {29'd0, v4, b4, d4}, 0);
    clr_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_nodone%0d", k), {13'd0, o4, v4, b4, d4}, 0);
    end
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("restart_first", 32'(o4), 32'h0001);
    tick();
    chk("restart_second", 32'(o4), 32'h0002);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
